bf_mem_arbiter: RTL and testbench
=================================

// Module: bf_mem_arbiter
// PURPOSE
//   Shares the 8-bit bidirectional uio bus of the BF CPU between two requesters:
//   instruction fetch (read-only) and tape data (read/write). Grants one access
//   at a time, round-robin on ties. Each granted access runs a fixed external-SRAM
//   sequence: address-high, address-low, then data. Sits between the CPU core and
//   the uio_in/uio_out/uio_oe pins of the top level.
// PARAMETERS
//   ADDR_W    16  requester address width, 1..16; zero-extended to 16 bits on the bus
//   WAIT_CYC  1   extra data-phase cycles for external memory access time, 0..15
// PORTS
//   clk        in   1       clock; all state updates on the rising edge
//   rst        in   1       synchronous reset, active high
//   if_req     in   1       instruction-fetch request; held high until if_ack
//   if_addr    in   ADDR_W  instruction-fetch address
//   if_ack     out  1       one-cycle pulse; fetch done, rdata valid
//   d_req      in   1       tape-data request; held high until d_ack
//   d_we       in   1       1 = write, 0 = read
//   d_addr     in   ADDR_W  tape-data address
//   d_wdata    in   8       tape-data write byte
//   d_ack      out  1       one-cycle pulse; data access done
//   rdata      out  8       last byte read; shared by both requesters
//   bus_in     in   8       uio_in
//   bus_out    out  8       uio_out
//   bus_oe     out  8       uio_oe; always 8'h00 or 8'hFF
//   ale_hi     out  1       address-high latch strobe
//   ale_lo     out  1       address-low latch strobe
//   rd_en      out  1       external read enable
//   wr_en      out  1       external write enable
//   busy       out  1       high in every state except IDLE
// BEHAVIOUR
//   Reset values: all outputs 0, rdata 8'h00, state IDLE, last_grant = IFETCH.
//   States: IDLE -> ADDR_HI -> ADDR_LO -> XFER -> ACK -> IDLE.
//   IDLE
//     - No request: bus_oe = 00.
//     - Any request: latch grant, addr, we, wdata, then go to ADDR_HI.
//     - if_req only: grant IFETCH. d_req only: grant DATA.
//     - Both: grant the requester that is not last_grant. After reset, DATA wins
//       the first tie.
//     - Update last_grant when granting.
//   ADDR_HI, 1 cycle: bus_out = addr16[15:8], bus_oe = FF, ale_hi = 1.
//   ADDR_LO, 1 cycle: bus_out = addr16[7:0], bus_oe = FF, ale_lo = 1.
//   XFER, WAIT_CYC+1 cycles, counted by a down-counter:
//     - read: bus_oe = 00, rd_en = 1; sample bus_in into rdata on the last cycle.
//     - write: bus_oe = FF, bus_out = wdata, wr_en = 1; rdata unchanged.
//     - IFETCH grants always read; d_we is ignored for them.
//   ACK, 1 cycle: pulse the granted ack, bus_oe = 00. Requests are ignored in this
//     cycle; the requester may still hold req high. Next state is always IDLE.
//   Latency: req seen in IDLE at cycle N -> ack at cycle N+4+WAIT_CYC.
//     Back-to-back throughput is one access per 5+WAIT_CYC cycles.
//   Latched inputs: changes to addr, we or wdata after the grant have no effect.
//     A req that drops mid-access still completes and is still acked.
//   rdata holds its value until the next read completes.
//   bus_out = 00 whenever bus_oe = 00.
//   Strobes are mutually exclusive; at most one of ale_hi, ale_lo, rd_en, wr_en
//     is high in any cycle.
//   Reset mid-access: next cycle is IDLE with all outputs 0 and no ack; the
//     interrupted access is abandoned.
// TESTING
//   1. WAIT_CYC=1, if_req at addr 16'h1234, bus_in = 8'h2B -> ale_hi with bus_out
//      12, ale_lo with 34, rd_en for 2 cycles, if_ack 5 cycles after the request,
//      rdata = 2B.
//   2. d_req with d_we=1, addr 16'h00FF, wdata 8'h5A -> bus_out 00, FF, then 5A
//      with bus_oe FF and wr_en for 2 cycles; d_ack pulses; rdata unchanged.
//   3. if_req and d_req held together after reset -> grant order D, I, D, I;
//      each ack is a single-cycle pulse.
//   4. rst asserted during XFER -> next cycle IDLE, all outputs 0; no ack for the
//      aborted access.
//   5. WAIT_CYC=0, req held continuously -> one ack every 5 cycles.
//   6. Throughout every test -> never two strobes high in the same cycle; bus_oe
//      is 00 or FF only.

Source files
------------

// File: rtl/bf_mem_arbiter.sv
// bf_mem_arbiter: round-robin arbiter sharing the 8-bit uio SRAM bus between instruction fetch and tape data
module bf_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [7:0]        d_wdata,
  output logic              d_ack,
  output logic [7:0]        rdata,
  input  logic [7:0]        bus_in,
  output logic [7:0]        bus_out,
  output logic [7:0]        bus_oe,
  output logic              ale_hi,
  output logic              ale_lo,
  output logic              rd_en,
  output logic              wr_en,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, XFER, ACK} state_t;
  state_t      state_q;
  logic        last_data_q, gnt_data_q, we_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q, rdata_q, bus_out_q, bus_oe_q;
  logic [3:0]  cnt_q;
  logic        if_ack_q, d_ack_q, ale_hi_q, ale_lo_q, rd_en_q, wr_en_q, busy_q;
  logic        gnt_data_d;
  logic [15:0] addr_d;
  assign gnt_data_d = d_req & (~if_req | ~last_data_q);
  assign addr_d     = gnt_data_d ? 16'(d_addr) : 16'(if_addr);
  assign if_ack  = if_ack_q;
  assign d_ack   = d_ack_q;
  assign rdata   = rdata_q;
  assign bus_out = bus_out_q;
  assign bus_oe  = bus_oe_q;
  assign ale_hi  = ale_hi_q;
  assign ale_lo  = ale_lo_q;
  assign rd_en   = rd_en_q;
  assign wr_en   = wr_en_q;
  assign busy    = busy_q;
  // access sequencer; every output is registered and set on entry to the state that owns it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_data_q <= 1'b0;
      gnt_data_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 8'h00;
      cnt_q       <= 4'd0;
      rdata_q     <= 8'h00;
      bus_out_q   <= 8'h00;
      bus_oe_q    <= 8'h00;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      ale_hi_q    <= 1'b0;
      ale_lo_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (if_req | d_req) begin
          state_q     <= ADDR_HI;
          gnt_data_q  <= gnt_data_d;
          last_data_q <= gnt_data_d;
          addr_q      <= addr_d;
          we_q        <= gnt_data_d & d_we;
          wdata_q     <= d_wdata;
          bus_out_q   <= addr_d[15:8];
          bus_oe_q    <= 8'hFF;
          ale_hi_q    <= 1'b1;
          busy_q      <= 1'b1;
        end
        ADDR_HI: begin
          state_q   <= ADDR_LO;
          bus_out_q <= addr_q[7:0];
          ale_hi_q  <= 1'b0;
          ale_lo_q  <= 1'b1;
        end
        ADDR_LO: begin
          state_q   <= XFER;
          cnt_q     <= 4'(WAIT_CYC);
          ale_lo_q  <= 1'b0;
          bus_out_q <= we_q ? wdata_q : 8'h00;
          bus_oe_q  <= {8{we_q}};
          wr_en_q   <= we_q;
          rd_en_q   <= ~we_q;
        end
        XFER: if (cnt_q == 4'd0) begin
          state_q   <= ACK;
          rdata_q   <= we_q ? rdata_q : bus_in;
          bus_out_q <= 8'h00;
          bus_oe_q  <= 8'h00;
          rd_en_q   <= 1'b0;
          wr_en_q   <= 1'b0;
          if_ack_q  <= ~gnt_data_q;
          d_ack_q   <= gnt_data_q;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        ACK: begin
          state_q  <= IDLE;
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
          busy_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bf_mem_arbiter.sv
// tb_bf_mem_arbiter: table vectors, corner sequences and random traffic against a transaction-level model
module tb_bf_mem_arbiter;
  localparam int W = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0] if_addr = 16'h0, d_addr = 16'h0;
  logic [7:0]  d_wdata = 8'h0, bus_in = 8'h0;
  logic        if_ack, d_ack, ale_hi, ale_lo, rd_en, wr_en, busy;
  logic [7:0]  rdata, bus_out, bus_oe;
  logic        if_req1 = 1'b0;
  logic        if_ack1, d_ack1, ale_hi1, ale_lo1, rd_en1, wr_en1, busy1;
  logic [7:0]  rdata1, bus_out1, bus_oe1;
  bf_mem_arbiter #(.ADDR_W(16), .WAIT_CYC(W)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .ale_hi(ale_hi), .ale_lo(ale_lo), .rd_en(rd_en), .wr_en(wr_en), .busy(busy));
  bf_mem_arbiter #(.ADDR_W(16), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .if_req(if_req1), .if_addr(16'h0100), .if_ack(if_ack1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(8'h00), .d_ack(d_ack1),
    .rdata(rdata1), .bus_in(bus_in), .bus_out(bus_out1), .bus_oe(bus_oe1),
    .ale_hi(ale_hi1), .ale_lo(ale_lo1), .rd_en(rd_en1), .wr_en(wr_en1), .busy(busy1));
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  logic [30:0] act_v;
  assign act_v = {if_ack, d_ack, rdata, bus_out, bus_oe, ale_hi, ale_lo, rd_en, wr_en, busy};
  bit          m_act = 1'b0, m_gd = 1'b0, m_we = 1'b0, m_last = 1'b0;
  int          m_t = 0;
  logic [15:0] m_a = 16'h0;
  logic [7:0]  m_wd = 8'h0, m_rd = 8'h0;
  always @(posedge clk) begin
    if (rst) begin
      m_act = 1'b0; m_t = 0; m_last = 1'b0; m_rd = 8'h00;
    end else if (!m_act) begin
      if (if_req || d_req) begin
        m_gd = d_req && (!if_req || !m_last);
        m_last = m_gd;
        m_a = m_gd ? d_addr : if_addr;
        m_we = m_gd && d_we;
        m_wd = d_wdata;
        m_act = 1'b1;
        m_t = 1;
      end
    end else begin
      if (m_t == 3 + W && !m_we) m_rd = bus_in;
      m_t++;
      if (m_t == 5 + W) begin m_act = 1'b0; m_t = 0; end
    end
  end
  function automatic logic [30:0] exp_vec();
    logic [30:0] v = {2'b00, m_rd, 21'h0};
    if (m_act) begin
      if (m_t == 1) v = {2'b00, m_rd, m_a[15:8], 8'hFF, 5'b10001};
      else if (m_t == 2) v = {2'b00, m_rd, m_a[7:0], 8'hFF, 5'b01001};
      else if (m_t <= 3 + W) v = m_we ? {2'b00, m_rd, m_wd, 8'hFF, 5'b00011} : {2'b00, m_rd, 16'h0000, 5'b00101};
      else v = {~m_gd, m_gd, m_rd, 16'h0000, 5'b00001};
    end
    return v;
  endfunction
  always @(negedge clk) if (chk_en) begin
    checks++;
    if (act_v !== exp_vec()) begin
      errors++;
      $display("FAIL model_cycle at %0t actual %h required %h", $time, act_v, exp_vec());
    end
    checks++;
    if (!$onehot0({ale_hi, ale_lo, rd_en, wr_en}) || !(bus_oe == 8'h00 || bus_oe == 8'hFF) || (bus_oe == 8'h00 && bus_out != 8'h00)) begin
      errors++;
      $display("FAIL invariant at %0t actual strobes %b oe %h out %h required onehot0/00-FF/quiet bus", $time, {ale_hi, ale_lo, rd_en, wr_en}, bus_oe, bus_out);
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", nm, act, req);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  typedef struct {
    logic ifr, dr, we;
    logic [15:0] ia, da;
    logic [7:0] wd, bi;
    logic egd, ewe;
    logic [7:0] hi, lo, erd;
  } vec_t;
  vec_t tbl[6];
  int n, cyc, last;
  logic prev;
  logic [3:0] order;
  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 8'h00, 8'h2B, 1'b0, 1'b0, 8'h12, 8'h34, 8'h2B};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h00FF, 8'h5A, 8'h33, 1'b1, 1'b1, 8'h00, 8'hFF, 8'h2B};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 16'h0A0B, 16'hC0DE, 8'h00, 8'h77, 1'b0, 1'b0, 8'h0A, 8'h0B, 8'h77};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 16'h1111, 16'hBEEF, 8'hC3, 8'h99, 1'b1, 1'b1, 8'hBE, 8'hEF, 8'h77};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 8'h11, 8'hA5, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hA5};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 16'h2222, 16'h0000, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    repeat (3) step();
    rst = 1'b0;
    chk("reset_state", act_v, 0);
    chk("reset_state_w0", {if_ack1, d_ack1, rdata1, bus_out1, bus_oe1, ale_hi1, ale_lo1, rd_en1, wr_en1, busy1}, 0);
    chk_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if_req = tbl[i].ifr; d_req = tbl[i].dr; d_we = tbl[i].we;
      if_addr = tbl[i].ia; d_addr = tbl[i].da; d_wdata = tbl[i].wd; bus_in = tbl[i].bi;
      step();
      chk("addr_hi", {ale_hi, bus_out, bus_oe}, {1'b1, tbl[i].hi, 8'hFF});
      if_addr = ~tbl[i].ia; d_addr = ~tbl[i].da; d_wdata = ~tbl[i].wd; d_we = ~tbl[i].we;
      step();
      chk("addr_lo", {ale_lo, bus_out, bus_oe}, {1'b1, tbl[i].lo, 8'hFF});
      for (int k = 0; k <= W; k++) begin
        step();
        chk("xfer", {rd_en, wr_en, bus_out, bus_oe}, tbl[i].ewe ? {2'b01, tbl[i].wd, 8'hFF} : {2'b10, 16'h0000});
      end
      step();
      chk("ack", {if_ack, d_ack, rdata}, {~tbl[i].egd, tbl[i].egd, tbl[i].erd});
      if_req = 1'b0; d_req = 1'b0;
      step();
      chk("idle_after", {busy, if_ack, d_ack}, 0);
    end
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 16'h0040; d_addr = 16'h8000;
    n = 0; cyc = 0; prev = 1'b0; order = 4'h0;
    while (n < 4 && cyc < 60) begin
      step(); cyc++;
      if (if_ack || d_ack) begin
        chk("ack_pulse", {if_ack & d_ack, prev}, 0);
        order = {order[2:0], d_ack};
        n++;
      end
      prev = if_ack | d_ack;
    end
    chk("tie_acks", n, 4);
    chk("tie_order", order, 4'b1010);
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) step();
    if_req = 1'b1; if_addr = 16'h4321;
    step(); step(); step();
    chk("in_xfer", rd_en, 1);
    rst = 1'b1;
    step();
    chk("rst_mid", act_v, 0);
    rst = 1'b0; if_req = 1'b0;
    repeat (8) begin
      step();
      chk("no_ack_after_abort", {if_ack, d_ack}, 0);
    end
    if_req1 = 1'b1;
    n = 0; cyc = 0; last = -1;
    while (n < 4 && cyc < 60) begin
      step(); cyc++;
      if (if_ack1) begin
        if (last >= 0) chk("w0_period", cyc - last, 5);
        last = cyc;
        n++;
      end
    end
    chk("w0_acks", n, 4);
    if_req1 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      step();
      bus_in = 8'($urandom);
      if (if_req && if_ack) if_req = 1'($urandom_range(0, 1));
      else if (!if_req) if_req = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) if_addr = 16'($urandom);
      if (d_req && d_ack) d_req = 1'($urandom_range(0, 1));
      else if (!d_req) d_req = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) begin
        d_addr = 16'($urandom); d_wdata = 8'($urandom); d_we = 1'($urandom_range(0, 1));
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (12) step();
    chk("final_idle", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
